ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the 64-bit RISC-V core.
- Sits directly upstream of the ALU. Captures decoded operands and control, and resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives the ALU's a, b and 4-bit alu_control inputs.
- Detects load-use hazards and inserts bubbles. Honours downstream backpressure and flush.

Parameters:
XLEN, 64, datapath width
REG_BITS, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  kill held and incoming instruction
in_valid  in  1  decode stage offers an instruction
in_ready  out  1  stage accepts the offered instruction this cycle
in_pc  in  XLEN  instruction PC
in_rs1_data  in  XLEN  register-file read 1
in_rs2_data  in  XLEN  register-file read 2
in_imm  in  XLEN  sign-extended immediate
in_rs1  in  REG_BITS  source index 1
in_rs2  in  REG_BITS  source index 2
in_rd  in  REG_BITS  destination index
in_alu_control  in  4  ALU opcode, ALU encoding
in_a_src  in  2  00 rs1, 01 pc, 1x zero
in_b_src  in  1  0 rs2, 1 imm
in_reg_write  in  1  writes rd
in_mem_read  in  1  load
in_mem_write  in  1  store
mem_rd  in  REG_BITS  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes rd
mem_result  in  XLEN  EX/MEM result
wb_rd  in  REG_BITS  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
wb_result  in  XLEN  MEM/WB writeback value
ex_ready  in  1  downstream consumes the held instruction
ex_valid  out  1  held instruction valid
alu_a  out  XLEN  ALU operand a
alu_b  out  XLEN  ALU operand b
alu_control  out  4  ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value, for stores
ex_pc  out  XLEN  held PC
ex_rd  out  REG_BITS  held destination
ex_reg_write  out  1  gated by ex_valid
ex_mem_read  out  1  gated by ex_valid
ex_mem_write  out  1  gated by ex_valid
load_use_stall  out  1  load-use hazard bubble being inserted

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: every held field is 0 and ex_valid=0. Resulting outputs:
  - alu_a=0, alu_b=0, alu_control=0, ex_store_data=0, ex_pc=0, ex_rd=0.
  - ex_reg_write, ex_mem_read and ex_mem_write are 0.
  - load_use_stall=0 and in_ready=1.
- Load-use hazard: load_use_stall = ex_valid & held mem_read & held rd!=0 & in_valid & (in_rs1==held rd | in_rs2==held rd).
- Ready: in_ready = flush | (!load_use_stall & (!ex_valid | ex_ready)).
- Register update, evaluated in priority order each rising edge:
  1. flush: ex_valid<=0 and held control bits <=0. The incoming instruction is discarded even if in_valid.
  2. in_valid & in_ready: capture all in_* fields; ex_valid<=1. Latency is exactly one cycle.
  3. load_use_stall & ex_ready: ex_valid<=0 (bubble). Decode holds its instruction.
  4. ex_ready: ex_valid<=0.
  5. Otherwise hold all fields unchanged.
- Forwarding is combinational from the held indices, with the same rule for rs1 and rs2:
  - Use mem_result if mem_reg_write & mem_rd!=0 & mem_rd==held index.
  - Else use wb_result if wb_reg_write & wb_rd!=0 & wb_rd==held index.
  - Else use the held register data.
  - MEM takes priority over WB. x0 is never forwarded.
- Operand select:
  - alu_a = fwd_rs1, held pc, or 0, per held a_src.
  - alu_b = held imm if held b_src=1, else fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- alu_control = held opcode, passed through unmodified.
- Outputs are combinational from held state and forwarding inputs. No cycle is added between this stage and the ALU.
- Reset mid-operation discards the held instruction immediately.

Optional Feature:
- Macro EX_OPERAND_STAGE_PERF_EN.
- When defined, adds two outputs:
  - bubble_count, 32 bits: increments on each cycle where rule 3 fires.
  - flush_count, 32 bits: increments on each flush cycle where ex_valid=1.
- Both counters reset to 0 on rst and saturate at 0xFFFFFFFF.
- When undefined, neither port nor counter exists. Remaining behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> ex_valid=0 and alu_a=alu_b=0 immediately, with no clock edge.
- Basic issue: in_rs1_data=5, in_imm=7, b_src=1, alu_control=0010, ex_ready=1 -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_control=0010.
- Forward priority: held rs1=3; mem_rd=3/mem_result=0xAA and wb_rd=3/wb_result=0xBB, both writing -> alu_a=0xAA. Drop mem_reg_write -> alu_a=0xBB. Repeat with rs1=0 -> alu_a=held data.
- Load-use: held load rd=4, incoming in_rs2=4, ex_ready=1 -> load_use_stall=1, in_ready=0, next cycle ex_valid=0. The following cycle the instruction is accepted.
- Backpressure/flush: ex_ready=0 for 3 cycles -> all outputs stable and in_ready=0. Then flush=1 with in_valid=1 -> next cycle ex_valid=0 and ex_reg_write=0.
- Perf (macro defined): 2 load-use bubbles + 1 flush of a valid instruction -> bubble_count=2, flush_count=1.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Optional perf counters (bubble_count, flush_count) are enabled by EX_OPERAND_STAGE_PERF_EN.
module ex_operand_stage #(
    parameter int XLEN     = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rs1_data,
    input  logic [XLEN-1:0]     in_rs2_data,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [REG_BITS-1:0] in_rs1,
    input  logic [REG_BITS-1:0] in_rs2,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic [3:0]          in_alu_control,
    input  logic [1:0]          in_a_src,
    input  logic                in_b_src,
    input  logic                in_reg_write,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_reg_write,
    input  logic [XLEN-1:0]     mem_result,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_reg_write,
    input  logic [XLEN-1:0]     wb_result,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic [3:0]          alu_control,
    output logic [XLEN-1:0]     ex_store_data,
    output logic [XLEN-1:0]     ex_pc,
    output logic [REG_BITS-1:0] ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                load_use_stall
`ifdef EX_OPERAND_STAGE_PERF_EN
    ,
    output logic [31:0]         bubble_count,
    output logic [31:0]         flush_count
`endif
);

    logic                vld_p1;
    logic [XLEN-1:0]     pc_p1;
    logic [XLEN-1:0]     rs1_data_p1;
    logic [XLEN-1:0]     rs2_data_p1;
    logic [XLEN-1:0]     imm_p1;
    logic [REG_BITS-1:0] rs1_p1;
    logic [REG_BITS-1:0] rs2_p1;
    logic [REG_BITS-1:0] rd_p1;
    logic [3:0]          alu_control_p1;
    logic [1:0]          a_src_p1;
    logic                b_src_p1;
    logic                reg_write_p1;
    logic                mem_read_p1;
    logic                mem_write_p1;

    logic [XLEN-1:0]     fwd_rs1;
    logic [XLEN-1:0]     fwd_rs2;

    // MEM beats WB; x0 is hardwired so it is never a forwarding target.
    function automatic logic [XLEN-1:0] forward(
        input logic [REG_BITS-1:0] idx,
        input logic [XLEN-1:0]     held,
        input logic [REG_BITS-1:0] m_rd,
        input logic                m_we,
        input logic [XLEN-1:0]     m_val,
        input logic [REG_BITS-1:0] w_rd,
        input logic                w_we,
        input logic [XLEN-1:0]     w_val
    );
        logic [XLEN-1:0] r;
        r = held;
        if (m_we && (m_rd != '0) && (m_rd == idx))
            r = m_val;
        else if (w_we && (w_rd != '0) && (w_rd == idx))
            r = w_val;
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign load_use_stall = vld_p1 && mem_read_p1 && (rd_p1 != '0) && in_valid &&
                            ((in_rs1 == rd_p1) || (in_rs2 == rd_p1));
    assign in_ready       = flush || (!load_use_stall && (!vld_p1 || ex_ready));

    // ID -> EX register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1         <= 1'b0;
            pc_p1          <= '0;
            rs1_data_p1    <= '0;
            rs2_data_p1    <= '0;
            imm_p1         <= '0;
            rs1_p1         <= '0;
            rs2_p1         <= '0;
            rd_p1          <= '0;
            alu_control_p1 <= '0;
            a_src_p1       <= '0;
            b_src_p1       <= 1'b0;
            reg_write_p1   <= 1'b0;
            mem_read_p1    <= 1'b0;
            mem_write_p1   <= 1'b0;
        end else if (flush) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
        end else if (in_valid && in_ready) begin
            vld_p1         <= 1'b1;
            pc_p1          <= in_pc;
            rs1_data_p1    <= in_rs1_data;
            rs2_data_p1    <= in_rs2_data;
            imm_p1         <= in_imm;
            rs1_p1         <= in_rs1;
            rs2_p1         <= in_rs2;
            rd_p1          <= in_rd;
            alu_control_p1 <= in_alu_control;
            a_src_p1       <= in_a_src;
            b_src_p1       <= in_b_src;
            reg_write_p1   <= in_reg_write;
            mem_read_p1    <= in_mem_read;
            mem_write_p1   <= in_mem_write;
        end else if (ex_ready) begin
            // Covers both the load-use bubble and a plain drain.
            vld_p1 <= 1'b0;
        end
    end

    // EX operand boundary: combinational into the ALU
    always_comb begin
        fwd_rs1 = forward(rs1_p1, rs1_data_p1, mem_rd, mem_reg_write, mem_result,
                          wb_rd, wb_reg_write, wb_result);
        fwd_rs2 = forward(rs2_p1, rs2_data_p1, mem_rd, mem_reg_write, mem_result,
                          wb_rd, wb_reg_write, wb_result);
        alu_a   = '0;
        if (a_src_p1 == 2'b00)
            alu_a = fwd_rs1;
        else if (a_src_p1 == 2'b01)
            alu_a = pc_p1;
        alu_b = b_src_p1 ? imm_p1 : fwd_rs2;
    end

    assign ex_valid      = vld_p1;
    assign alu_control   = alu_control_p1;
    assign ex_store_data = fwd_rs2;
    assign ex_pc         = pc_p1;
    assign ex_rd         = rd_p1;
    assign ex_reg_write  = vld_p1 && reg_write_p1;
    assign ex_mem_read   = vld_p1 && mem_read_p1;
    assign ex_mem_write  = vld_p1 && mem_write_p1;

`ifdef EX_OPERAND_STAGE_PERF_EN
    logic bubble_fire;
    logic flush_fire;

    // A stall with no flush forces in_ready low, so capture cannot pre-empt the bubble.
    assign bubble_fire = !flush && load_use_stall && ex_ready;
    assign flush_fire  = flush && vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (bubble_fire)
                bubble_count <= sat_inc(bubble_count);
            if (flush_fire)
                flush_count <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues expected ALU-side transactions,
// a monitor pops them whenever the stage hands an instruction downstream.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_alu_control;
    logic [1:0]  in_a_src;
    logic        in_b_src, in_reg_write, in_mem_read, in_mem_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [63:0] mem_result, wb_result;
    logic        ex_ready;
    logic        ex_valid;
    logic [63:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
`ifdef EX_OPERAND_STAGE_PERF_EN
    logic [31:0] bubble_count, flush_count;
`endif

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_control(in_alu_control),
        .in_a_src(in_a_src), .in_b_src(in_b_src), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
`ifdef EX_OPERAND_STAGE_PERF_EN
        , .bubble_count(bubble_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctl;
        logic [63:0] store;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [2:0]  flags;   // {reg_write, mem_read, mem_write}
    } tx_t;

    tx_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, rs1d, rs2d, imm,
                         input logic [4:0] rs1, rs2, rd, input logic [3:0] ctl,
                         input logic [1:0] asrc, input logic bsrc, rw, mr, mw);
        in_valid = 1'b1; in_pc = pc; in_rs1_data = rs1d; in_rs2_data = rs2d; in_imm = imm;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_alu_control = ctl; in_a_src = asrc;
        in_b_src = bsrc; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic expect_tx(input logic [63:0] a, b, input logic [3:0] ctl,
                             input logic [63:0] store, pc, input logic [4:0] rd,
                             input logic [2:0] flags);
        tx_t t;
        t.a = a; t.b = b; t.ctl = ctl; t.store = store; t.pc = pc; t.rd = rd; t.flags = flags;
        exp_q.push_back(t);
    endtask

    task automatic no_fwd();
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_rd = '0; wb_rd = '0; mem_result = '0; wb_result = '0;
    endtask

    // Monitor: every instruction handed downstream is matched against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ex_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_pc", ex_pc, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    tx_t e;
                    e = exp_q.pop_front();
                    chk("tx_alu_a", alu_a, e.a);
                    chk("tx_alu_b", alu_b, e.b);
                    chk("tx_alu_control", {60'd0, alu_control}, {60'd0, e.ctl});
                    chk("tx_store_data", ex_store_data, e.store);
                    chk("tx_pc", ex_pc, e.pc);
                    chk("tx_rd", {59'd0, ex_rd}, {59'd0, e.rd});
                    chk("tx_flags", {61'd0, ex_reg_write, ex_mem_read, ex_mem_write},
                        {61'd0, e.flags});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_alu_control = '0; in_a_src = '0;
        in_b_src = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        no_fwd();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_alu_control", {60'd0, alu_control}, 64'd0);
        chk("rst_store_data", ex_store_data, 64'd0);
        chk("rst_pc_rd", ex_pc | {59'd0, ex_rd}, 64'd0);
        chk("rst_ctrl", {61'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 64'd0);
        chk("rst_stall", {63'd0, load_use_stall}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Basic issue: a=rs1 data, b=imm
        drive(64'h100, 64'd5, 64'd9, 64'd7, 5'd1, 5'd2, 5'd3, 4'b0010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tx(64'd5, 64'd7, 4'b0010, 64'd9, 64'h100, 5'd3, 3'b100);
        step();
        idle();
        @(negedge clk);
        chk("basic_ex_valid", {63'd0, ex_valid}, 64'd1);
        step();

        // a from PC (store), then a forced zero with an all-ones immediate, back to back
        drive(64'h200, 64'd0, 64'h66, 64'd0, 5'd0, 5'd6, 5'd7, 4'b0110, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_tx(64'h200, 64'h66, 4'b0110, 64'h66, 64'h200, 5'd7, 3'b001);
        step();
        drive(64'h204, 64'h88, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 5'd10, 5'd9, 4'b1000,
              2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tx(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 64'h10, 64'h204, 5'd9, 3'b100);
        step();
        idle();
        step();

        // Forward priority on a held instruction
        ex_ready = 1'b0;
        mem_rd = 5'd3; mem_reg_write = 1'b1; mem_result = 64'hAA;
        wb_rd = 5'd3; wb_reg_write = 1'b1; wb_result = 64'hBB;
        drive(64'h300, 64'h11, 64'h22, 64'd0, 5'd3, 5'd5, 5'd12, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_tx(64'hBB, 64'h22, 4'b0000, 64'h22, 64'h300, 5'd12, 3'b100);
        step();
        idle();
        @(negedge clk);
        chk("fwd_mem_priority", alu_a, 64'hAA);
        chk("fwd_hold_in_ready", {63'd0, in_ready}, 64'd0);
        mem_reg_write = 1'b0;
        #1 chk("fwd_wb", alu_a, 64'hBB);
        wb_reg_write = 1'b0;
        #1 chk("fwd_none", alu_a, 64'h11);
        wb_reg_write = 1'b1;
        wb_rd = 5'd5;
        #1 chk("fwd_wb_rs2_store", ex_store_data, 64'hBB);
        wb_rd = 5'd3;
        @(posedge clk); #1;
        ex_ready = 1'b1;
        step();

        // x0 source is never forwarded, even with rd=0 writers present
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 64'hAA;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 64'hBB;
        drive(64'h310, 64'h33, 64'h44, 64'd0, 5'd0, 5'd0, 5'd13, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_tx(64'h33, 64'h44, 4'b0001, 64'h44, 64'h310, 5'd13, 3'b100);
        step();
        idle();
        step();
        no_fwd();

        // Load-use: k=0 consumer reads rd via rs2, k=1 via rs1
        for (int k = 0; k < 2; k++) begin
            drive(64'h400 + 64'(k * 32), 64'h1000, 64'd0, 64'd8, 5'd1, 5'd0, 5'd4, 4'b0000,
                  2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
            expect_tx(64'h1000, 64'd8, 4'b0000, 64'd0, 64'h400 + 64'(k * 32), 5'd4, 3'b110);
            step();
            drive(64'h404 + 64'(k * 32), 64'h50, 64'h44, 64'd0,
                  (k == 0) ? 5'd1 : 5'd4, (k == 0) ? 5'd4 : 5'd2, 5'd5, 4'b0111,
                  2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            mem_rd = 5'd4; mem_reg_write = 1'b1; mem_result = 64'h1234;
            if (k == 0)
                expect_tx(64'h50, 64'h1234, 4'b0111, 64'h1234, 64'h404, 5'd5, 3'b100);
            else
                expect_tx(64'h1234, 64'h44, 4'b0111, 64'h44, 64'h424, 5'd5, 3'b100);
            @(negedge clk);
            chk("lu_stall", {63'd0, load_use_stall}, 64'd1);
            chk("lu_in_ready", {63'd0, in_ready}, 64'd0);
            step();
            @(negedge clk);
            chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
            chk("lu_bubble_ready", {62'd0, load_use_stall, in_ready}, 64'd1);
            step();
            idle();
            step();
            no_fwd();
        end

        // Backpressure then flush with a competing incoming instruction
        ex_ready = 1'b0;
        drive(64'h500, 64'h77, 64'd0, 64'd3, 5'd1, 5'd2, 5'd6, 4'b0011, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {alu_a[31:0], alu_b[23:0], alu_control, ex_valid, ex_reg_write,
                            ex_mem_write, in_ready}, {32'h77, 24'd3, 4'b0011, 4'b1110});
            @(posedge clk); #1;
        end
        drive(64'h600, 64'h1, 64'h2, 64'd0, 5'd1, 5'd2, 5'd8, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_cleared", {61'd0, ex_valid, ex_reg_write, ex_mem_write}, 64'd0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef EX_OPERAND_STAGE_PERF_EN
        chk("perf_bubbles", {32'd0, bubble_count}, 64'd2);
        chk("perf_flushes", {32'd0, flush_count}, 64'd1);
`endif

        // Asynchronous reset while holding an instruction
        drive(64'h700, 64'h99, 64'd0, 64'h55, 5'd1, 5'd2, 5'd9, 4'b0101, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        #2;
        chk("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("async_rst_operands", alu_a | alu_b, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_ready = 1'b1;
        step();
        step();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
